// File: rtl/vga_pkg.sv
// Shared constants, state encoding and helpers for the VGA back-buffer frame writer.
package vga_pkg;

    // Frame geometry
    localparam int X_MAX          = 240;
    localparam int TILES_X        = 30;
    localparam int TILES_Y        = 33;
    localparam int SCORE_ADDR0    = 63360;
    localparam int SCORE_X_OFFSET = 8;
    localparam int SCORE_X_WIDTH  = 56;
    localparam int SCORE_DIGITS   = 7;
    localparam int IDLE_ADDR      = 65535;

    // Terminal counts, decoded explicitly instead of relying on counter wrap
    localparam logic [4:0] TX_LAST    = 5'(TILES_X - 1);
    localparam logic [5:0] TY_LAST    = 6'(TILES_Y - 1);
    localparam logic [2:0] DIGIT_LAST = 3'(SCORE_DIGITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_PIX,
        ST_SCORE,
        ST_DRAIN
    } frame_writer_state_t;

    // Which ROM feeds the RAM data port on the cycle after issue
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_TILE,
        SRC_GLYPH
    } pix_src_t;

    // Digit 0 is the most significant nibble [27:24]
    function automatic logic [3:0] bcd_digit(input logic [27:0] bcd, input logic [2:0] idx);
        logic [27:0] shifted;
        shifted = bcd >> (5'd24 - {idx, 2'b00});
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/vga_frame_writer_pix_walker.sv
// 8x8 pixel walker: px runs fastest, then py; shared by the maze and score phases.
module pix_walker (
    input  logic       clk,
    input  logic       srst,
    input  logic       clear,
    input  logic       step,
    output logic [2:0] px,
    output logic [2:0] py,
    output logic       last_pix
);

    logic [2:0] px_reg;
    logic [2:0] py_reg;

    // Advance one pixel per step; clear has priority so a restart lands on (0,0)
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            px_reg <= 3'd0;
            py_reg <= 3'd0;
        end else if (step) begin
            if (px_reg == 3'd7) begin
                px_reg <= 3'd0;
                py_reg <= (py_reg == 3'd7) ? 3'd0 : py_reg + 3'd1;
            end else begin
                px_reg <= px_reg + 3'd1;
            end
        end
    end

    assign px       = px_reg;
    assign py       = py_reg;
    assign last_pix = (px_reg == 3'd7) && (py_reg == 3'd7);

endmodule

// File: rtl/vga_frame_writer.sv
// Renders the maze tile map and the score into the VGA back buffer, one byte per cycle,
// starting a fresh pass on every buffer swap.
module vga_frame_writer
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        buf_sel,
    input  logic [27:0] score_bcd,
    output logic [9:0]  tmap_addr,
    input  logic [7:0]  tmap_data,
    output logic [13:0] tile_rom_addr,
    input  logic [7:0]  tile_rom_data,
    output logic [9:0]  glyph_addr,
    input  logic [7:0]  glyph_data,
    output logic [15:0] addrWrite,
    output logic [7:0]  dataWrite,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    frame_writer_state_t state_reg, state_next;

    logic        buf_sel_q;
    logic        swap;
    logic [27:0] score_reg;
    logic [4:0]  tx_reg;
    logic [5:0]  ty_reg;
    logic [2:0]  digit_reg;
    logic [7:0]  tile_reg;
    logic [15:0] addr_reg;
    pix_src_t    src_reg;
    logic        done_reg;
    logic        overrun_reg;

    logic        pix_step;
    logic        tile_adv;
    logic        digit_adv;
    logic        issue_maze;
    logic        issue_score;

    logic [2:0]  px;
    logic [2:0]  py;
    logic        last_pix;

    logic [3:0]  digit_val;
    logic        digit_blank;
    logic [9:0]  tmap_index;
    logic [15:0] maze_x;
    logic [15:0] maze_y;
    logic [15:0] maze_addr;
    logic [15:0] score_addr;

    assign swap = buf_sel ^ buf_sel_q;

    pix_walker u_pix_walker (
        .clk      (clk),
        .srst     (rst),
        .clear    (swap),
        .step     (pix_step),
        .px       (px),
        .py       (py),
        .last_pix (last_pix)
    );

    // Address arithmetic, all 16-bit unsigned
    assign digit_val   = bcd_digit(score_reg, digit_reg);
    assign digit_blank = (digit_val > 4'd9);
    assign tmap_index  = {4'b0, ty_reg} * 10'(TILES_X) + {5'b0, tx_reg};
    assign maze_x      = {8'b0, tx_reg, px};
    assign maze_y      = {7'b0, ty_reg, py};
    assign maze_addr   = maze_x + maze_y * 16'(X_MAX);
    assign score_addr  = 16'(SCORE_ADDR0 + SCORE_X_OFFSET) + {10'b0, digit_reg, 3'b000}
                       + {13'b0, px} + {13'b0, py} * 16'(SCORE_X_WIDTH);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and per-cycle pixel issue; a swap always restarts at tile (0,0)
    always_comb begin
        state_next  = state_reg;
        pix_step    = 1'b0;
        tile_adv    = 1'b0;
        digit_adv   = 1'b0;
        issue_maze  = 1'b0;
        issue_score = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_IDLE;
            end
            ST_FETCH: begin
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                state_next = ST_PIX;
            end
            ST_PIX: begin
                issue_maze = 1'b1;
                pix_step   = 1'b1;
                if (last_pix) begin
                    if ((tx_reg == TX_LAST) && (ty_reg == TY_LAST)) begin
                        state_next = ST_SCORE;
                    end else begin
                        tile_adv   = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_SCORE: begin
                issue_score = 1'b1;
                pix_step    = 1'b1;
                if (last_pix) begin
                    if (digit_reg == DIGIT_LAST) begin
                        state_next = ST_DRAIN;
                    end else begin
                        digit_adv = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (swap) begin
            state_next = ST_FETCH;
        end
    end

    // Tile/digit counters, score snapshot and fetched tile index
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg    <= 5'd0;
            ty_reg    <= 6'd0;
            digit_reg <= 3'd0;
            score_reg <= 28'd0;
            tile_reg  <= 8'd0;
        end else if (swap) begin
            tx_reg    <= 5'd0;
            ty_reg    <= 6'd0;
            digit_reg <= 3'd0;
            score_reg <= score_bcd;
        end else begin
            if (tile_adv) begin
                if (tx_reg == TX_LAST) begin
                    tx_reg <= 5'd0;
                    ty_reg <= ty_reg + 6'd1;
                end else begin
                    tx_reg <= tx_reg + 5'd1;
                end
            end
            if (digit_adv) begin
                digit_reg <= digit_reg + 3'd1;
            end
            if (state_reg == ST_LATCH) begin
                tile_reg <= tmap_data;
            end
        end
    end

    // Write pipeline: address and data source registered with issue; in-flight write survives a swap
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= 16'(IDLE_ADDR);
            src_reg  <= SRC_NONE;
        end else if (issue_maze) begin
            addr_reg <= maze_addr;
            src_reg  <= SRC_TILE;
        end else if (issue_score) begin
            addr_reg <= score_addr;
            src_reg  <= digit_blank ? SRC_NONE : SRC_GLYPH;
        end else begin
            addr_reg <= 16'(IDLE_ADDR);
            src_reg  <= SRC_NONE;
        end
    end

    // Swap edge detector, completion pulse and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_sel_q   <= buf_sel;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            buf_sel_q <= buf_sel;
            done_reg  <= (state_reg == ST_DRAIN) && !swap;
            if (swap && (state_reg != ST_IDLE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // RAM data follows the ROM selected when the pixel was issued
    always_comb begin
        dataWrite = 8'h00;
        case (src_reg)
            SRC_TILE:  dataWrite = tile_rom_data;
            SRC_GLYPH: dataWrite = glyph_data;
            default:   dataWrite = 8'h00;
        endcase
    end

    assign tmap_addr     = (state_reg == ST_FETCH) ? tmap_index : 10'd0;
    assign tile_rom_addr = (state_reg == ST_PIX) ? {tile_reg, py, px} : 14'd0;
    assign glyph_addr    = ((state_reg == ST_SCORE) && !digit_blank) ? {digit_val, py, px} : 10'd0;
    assign addrWrite     = addr_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_vga_frame_writer.sv
// Directed bench for vga_frame_writer with a scoreboard of expected RAM writes.
module tb_vga_frame_writer;

    localparam logic [15:0] IDLE_A = 16'hFFFF;

    logic        clk;
    logic        rst;
    logic        buf_sel;
    logic [27:0] score_bcd;
    logic [9:0]  tmap_addr;
    logic [7:0]  tmap_data;
    logic [13:0] tile_rom_addr;
    logic [7:0]  tile_rom_data;
    logic [9:0]  glyph_addr;
    logic [7:0]  glyph_data;
    logic [15:0] addrWrite;
    logic [7:0]  dataWrite;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int map_mode = 0;
    bit sb_en = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_w;

    vga_frame_writer dut (
        .clk           (clk),
        .rst           (rst),
        .buf_sel       (buf_sel),
        .score_bcd     (score_bcd),
        .tmap_addr     (tmap_addr),
        .tmap_data     (tmap_data),
        .tile_rom_addr (tile_rom_addr),
        .tile_rom_data (tile_rom_data),
        .glyph_addr    (glyph_addr),
        .glyph_data    (glyph_data),
        .addrWrite     (addrWrite),
        .dataWrite     (dataWrite),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents seen by the DUT (mode 1 makes every address bit observable)
    function automatic logic [7:0] map_fn(input logic [9:0] a, input int mode);
        if (mode == 0) return 8'h05;
        return a[7:0] ^ {6'b0, a[9:8]};
    endfunction

    function automatic logic [7:0] tile_rom_fn(input logic [13:0] a, input int mode);
        if (mode == 0) return a[7:0];
        return a[7:0] ^ a[13:6];
    endfunction

    function automatic logic [7:0] glyph_fn(input logic [9:0] a, input int mode);
        if (mode == 0) return a[7:0];
        return a[7:0] ^ {a[9:6], 4'b0};
    endfunction

    // One-cycle-latency memories
    always @(posedge clk) begin
        tmap_data     <= map_fn(tmap_addr, map_mode);
        tile_rom_data <= tile_rom_fn(tile_rom_addr, map_mode);
        glyph_data    <= glyph_fn(glyph_addr, map_mode);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected writes for the first ncyc cycles of a pass (cycle 0 = first busy cycle)
    task automatic push_cycles(input int ncyc, input logic [27:0] score, input int mode);
        int t, ph, p, px, py, tx, ty, s, dg, a;
        logic [3:0]  nib;
        logic [27:0] sh;
        logic [7:0]  tile, d;
        for (int k = 0; k < ncyc; k++) begin
            if (k < 990 * 66) begin
                t  = k / 66;
                ph = k % 66;
                if (ph >= 2) begin
                    p  = ph - 2;
                    px = p % 8;
                    py = p / 8;
                    tx = t % 30;
                    ty = t / 30;
                    a  = (tx * 8 + px) + (ty * 8 + py) * 240;
                    tile = map_fn(10'(ty * 30 + tx), mode);
                    d  = tile_rom_fn({tile, 3'(py), 3'(px)}, mode);
                    exp_q.push_back({a[15:0], d});
                end
            end else if (k < 990 * 66 + 7 * 64) begin
                s   = k - 990 * 66;
                dg  = s / 64;
                p   = s % 64;
                px  = p % 8;
                py  = p / 8;
                sh  = score >> (4 * (6 - dg));
                nib = sh[3:0];
                a   = 63368 + dg * 8 + px + py * 56;
                d   = (nib > 4'd9) ? 8'h00 : glyph_fn({nib, 3'(py), 3'(px)}, mode);
                exp_q.push_back({a[15:0], d});
            end
        end
    endtask

    // Scoreboard: every non-idle write must match the next expected write
    always @(negedge clk) begin
        if (sb_en && (addrWrite !== IDLE_A)) begin
            check("sb_pending", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                check("sb_write", {8'h00, addrWrite, dataWrite}, {8'h00, exp_w});
            end
        end
    end

    initial begin
        int bad, kk, nwr, busy_cnt, blank_cnt, done_cnt, off;
        bit got_done;
        logic [15:0] last_addr, max_addr;
        logic [7:0]  d63416;
        logic [23:0] first_w[0:64];

        rst = 1'b1;
        buf_sel = 1'b0;
        score_bcd = 28'd0;
        repeat (3) @(negedge clk);
        buf_sel = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Step 1: idle after reset with buf_sel constant
        @(negedge clk);
        check("rst_addr", addrWrite, IDLE_A);
        check("rst_data", dataWrite, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (addrWrite !== IDLE_A || dataWrite !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
                overrun !== 1'b0 || tmap_addr !== 10'd0 || tile_rom_addr !== 14'd0 || glyph_addr !== 10'd0)
                bad++;
        end
        check("idle_bad_cycles", bad, 0);
        $display("step idle: 1000 cycles observed");

        // Step 2: pass, then swap again 1000 cycles in
        sb_en = 1'b1;
        map_mode = 1;
        score_bcd = 28'h1234567;
        push_cycles(1000, 28'h1234567, 1);
        buf_sel = ~buf_sel;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (c == 0) check("p1_busy_start", busy, 1);
        end
        score_bcd = 28'h7654321;
        push_cycles(499, 28'h7654321, 1);
        buf_sel = ~buf_sel;
        @(negedge clk);
        kk = 0;
        check("ovr_flag", overrun, 1);
        check("ovr_busy", busy, 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            kk++;
            if (addrWrite !== IDLE_A) break;
        end
        check("ovr_first_addr", addrWrite, 0);
        $display("step overrun: restart first write at cycle %0d", kk);

        // Step 3: reset 500 cycles into the restarted pass
        while (kk < 499) begin
            @(negedge clk);
            kk++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_addr", addrWrite, IDLE_A);
        check("abort_busy", busy, 0);
        check("abort_overrun", overrun, 0);
        check("abort_done", done, 0);
        done_cnt = 0;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (busy !== 1'b0) bad++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_stays_idle", bad, 0);
        check("abort_sb_empty", exp_q.size(), 0);
        $display("step abort: outputs idle after reset");

        // Step 4: full pass
        map_mode = 0;
        score_bcd = 28'h0A12345;
        push_cycles(65789, 28'h0A12345, 0);
        buf_sel = ~buf_sel;
        nwr = 0; busy_cnt = 0; blank_cnt = 0; got_done = 0;
        last_addr = 16'd0; max_addr = 16'd0; d63416 = 8'h00;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got_done = 1;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            if (addrWrite !== IDLE_A) begin
                if (nwr < 65) first_w[nwr] = {addrWrite, dataWrite};
                nwr++;
                last_addr = addrWrite;
                if (addrWrite > max_addr) max_addr = addrWrite;
                if (addrWrite == 16'd63416) d63416 = dataWrite;
                if (addrWrite >= 16'd63368 && addrWrite < 16'd63816) begin
                    off = int'(addrWrite) - 63368;
                    if (((off % 56) / 8) == 1 && dataWrite == 8'h00) blank_cnt++;
                end
            end
        end

        // Step 5: swap in the done cycle starts a clean pass
        map_mode = 1;
        score_bcd = 28'h9B0C7D1;
        push_cycles(11999, 28'h9B0C7D1, 1);
        buf_sel = ~buf_sel;

        check("full_done_seen", got_done, 1);
        check("full_busy_cycles", busy_cnt, 65789);
        check("full_write_count", nwr, 63808);
        check("full_last_addr", last_addr, 63815);
        check("full_max_addr", max_addr, 63815);
        check("w0", first_w[0], {16'd0, 8'h40});
        check("w1", first_w[1], {16'd1, 8'h41});
        check("w8_py1", first_w[8], {16'd240, 8'h48});
        check("w64_tile10", first_w[64], {16'd8, 8'h40});
        check("score_d6_px0", d63416, 8'h40);
        check("blank_digit_writes", blank_cnt, 64);
        $display("step full pass: busy %0d cycles, %0d writes", busy_cnt, nwr);

        @(negedge clk);
        check("done_swap_busy", busy, 1);
        check("done_swap_done", done, 0);
        check("done_swap_overrun", overrun, 0);
        done_cnt = 0;
        for (int c = 0; c < 11999; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("single_done", done_cnt, 0);
        check("done_swap_overrun_end", overrun, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("final_sb_empty", exp_q.size(), 0);
        $display("step done-cycle swap: 12000 cycles observed");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
